// File: rtl/cmd_rr_arbiter.sv
// Round-robin arbiter sharing one controller command/response port between N_REQ requesters.
// One command in flight; the response is routed back to the requester that issued it.
module cmd_rr_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned IDX_WIDTH   = 2,
    parameter int unsigned KEY_WIDTH   = 64,
    parameter int unsigned VALUE_WIDTH = 64,
    parameter int unsigned TTL_WIDTH   = 32,
    parameter int unsigned CMD_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [N_REQ*CMD_WIDTH-1:0]   req_opcode,
    input  logic [N_REQ*KEY_WIDTH-1:0]   req_key,
    input  logic [N_REQ*VALUE_WIDTH-1:0] req_value,
    input  logic [N_REQ*TTL_WIDTH-1:0]   req_ttl,
    output logic [N_REQ-1:0]             req_ready,
    output logic [N_REQ-1:0]             rsp_valid,
    output logic                         rsp_success,
    output logic [VALUE_WIDTH-1:0]       rsp_value,
    output logic [TTL_WIDTH-1:0]         rsp_ttl,
    input  logic [N_REQ-1:0]             rsp_ready,
    output logic                         ctl_cmd_valid,
    output logic [CMD_WIDTH-1:0]         ctl_cmd_opcode,
    output logic [KEY_WIDTH-1:0]         ctl_cmd_key,
    output logic [VALUE_WIDTH-1:0]       ctl_cmd_value,
    output logic [TTL_WIDTH-1:0]         ctl_cmd_ttl,
    input  logic                         ctl_cmd_ready,
    input  logic                         ctl_resp_valid,
    input  logic                         ctl_resp_success,
    input  logic [VALUE_WIDTH-1:0]       ctl_resp_value,
    input  logic [TTL_WIDTH-1:0]         ctl_resp_ttl,
    output logic                         ctl_resp_ready,
    output logic                         busy,
    output logic [IDX_WIDTH-1:0]         grant_idx
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

    state_e                 state_q;
    logic [IDX_WIDTH-1:0]   rr_ptr_q;
    logic [IDX_WIDTH-1:0]   grant_idx_q;
    logic [CMD_WIDTH-1:0]   opcode_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] value_q;
    logic [TTL_WIDTH-1:0]   ttl_q;
    logic                   cmd_valid_q;
    logic                   resp_ready_q;
    logic                   busy_q;
    logic [N_REQ-1:0]       rsp_valid_q;
    logic                   rsp_success_q;
    logic [VALUE_WIDTH-1:0] rsp_value_q;
    logic [TTL_WIDTH-1:0]   rsp_ttl_q;

    logic [2*N_REQ-1:0]     req_dbl;
    logic [N_REQ-1:0]       req_rot;
    logic [IDX_WIDTH-1:0]   win_off;
    logic [IDX_WIDTH:0]     win_sum;
    logic [IDX_WIDTH-1:0]   win_idx;
    logic                   win_found;
    logic [N_REQ-1:0]       win_oh;
    logic [CMD_WIDTH-1:0]   sel_opcode;
    logic [KEY_WIDTH-1:0]   sel_key;
    logic [VALUE_WIDTH-1:0] sel_value;
    logic [TTL_WIDTH-1:0]   sel_ttl;
    logic [IDX_WIDTH-1:0]   rr_next;

    // Rotate the request vector so bit 0 is the requester at rr_ptr, then take the lowest set bit.
    always_comb begin
        req_dbl   = {req_valid, req_valid} >> rr_ptr_q;
        req_rot   = req_dbl[N_REQ-1:0];
        win_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = IDX_WIDTH'(k);
            end
        end
        win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
        if (win_sum >= (IDX_WIDTH + 1)'(N_REQ)) begin
            win_sum = win_sum - (IDX_WIDTH + 1)'(N_REQ);
        end
        win_idx   = win_sum[IDX_WIDTH-1:0];
        win_found = |req_valid;
        win_oh    = N_REQ'(1) << win_idx;
    end

    always_comb begin
        sel_opcode = '0;
        sel_key    = '0;
        sel_value  = '0;
        sel_ttl    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx == IDX_WIDTH'(i)) begin
                sel_opcode = req_opcode[i*CMD_WIDTH +: CMD_WIDTH];
                sel_key    = req_key[i*KEY_WIDTH +: KEY_WIDTH];
                sel_value  = req_value[i*VALUE_WIDTH +: VALUE_WIDTH];
                sel_ttl    = req_ttl[i*TTL_WIDTH +: TTL_WIDTH];
            end
        end
    end

    assign rr_next   = (grant_idx_q == IDX_WIDTH'(N_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
    assign req_ready = (state_q == StIdle && win_found) ? win_oh : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rr_ptr_q      <= '0;
            grant_idx_q   <= '0;
            opcode_q      <= '0;
            key_q         <= '0;
            value_q       <= '0;
            ttl_q         <= '0;
            cmd_valid_q   <= 1'b0;
            resp_ready_q  <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_success_q <= 1'b0;
            rsp_value_q   <= '0;
            rsp_ttl_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        opcode_q    <= sel_opcode;
                        key_q       <= sel_key;
                        value_q     <= sel_value;
                        ttl_q       <= sel_ttl;
                        grant_idx_q <= win_idx;
                        cmd_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    if (ctl_cmd_ready) begin
                        cmd_valid_q  <= 1'b0;
                        resp_ready_q <= 1'b1;
                        state_q      <= StWait;
                    end
                end
                StWait: begin
                    if (ctl_resp_valid) begin
                        rsp_success_q <= ctl_resp_success;
                        rsp_value_q   <= ctl_resp_value;
                        rsp_ttl_q     <= ctl_resp_ttl;
                        resp_ready_q  <= 1'b0;
                        rsp_valid_q   <= N_REQ'(1) << grant_idx_q;
                        state_q       <= StDeliver;
                    end
                end
                StDeliver: begin
                    if (rsp_ready[grant_idx_q]) begin
                        rsp_valid_q <= '0;
                        rr_ptr_q    <= rr_next;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ctl_cmd_valid  = cmd_valid_q;
    assign ctl_cmd_opcode = opcode_q;
    assign ctl_cmd_key    = key_q;
    assign ctl_cmd_value  = value_q;
    assign ctl_cmd_ttl    = ttl_q;
    assign ctl_resp_ready = resp_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_success    = rsp_success_q;
    assign rsp_value      = rsp_value_q;
    assign rsp_ttl        = rsp_ttl_q;
    assign busy           = busy_q;
    assign grant_idx      = grant_idx_q;

endmodule

// File: tb/tb_cmd_rr_arbiter.sv
// Self-checking bench for cmd_rr_arbiter: directed scenarios plus a response scoreboard.
module tb_cmd_rr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int KW = 64;
    localparam int VW = 64;
    localparam int TW = 32;
    localparam int CW = 8;
    localparam logic [63:0] VMASK = 64'hFFFF_0000_FFFF_0000;
    localparam logic [31:0] TMASK = 32'h0000_5A5A;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*CW-1:0] req_opcode;
    logic [N*KW-1:0] req_key;
    logic [N*VW-1:0] req_value;
    logic [N*TW-1:0] req_ttl;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic            rsp_success;
    logic [VW-1:0]   rsp_value;
    logic [TW-1:0]   rsp_ttl;
    logic [N-1:0]    rsp_ready;
    logic            ctl_cmd_valid;
    logic [CW-1:0]   ctl_cmd_opcode;
    logic [KW-1:0]   ctl_cmd_key;
    logic [VW-1:0]   ctl_cmd_value;
    logic [TW-1:0]   ctl_cmd_ttl;
    logic            ctl_cmd_ready;
    logic            ctl_resp_valid;
    logic            ctl_resp_success;
    logic [VW-1:0]   ctl_resp_value;
    logic [TW-1:0]   ctl_resp_ttl;
    logic            ctl_resp_ready;
    logic            busy;
    logic [IW-1:0]   grant_idx;

    cmd_rr_arbiter #(
        .N_REQ(N), .IDX_WIDTH(IW), .KEY_WIDTH(KW), .VALUE_WIDTH(VW), .TTL_WIDTH(TW), .CMD_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_opcode(req_opcode), .req_key(req_key),
        .req_value(req_value), .req_ttl(req_ttl), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_success(rsp_success), .rsp_value(rsp_value),
        .rsp_ttl(rsp_ttl), .rsp_ready(rsp_ready),
        .ctl_cmd_valid(ctl_cmd_valid), .ctl_cmd_opcode(ctl_cmd_opcode),
        .ctl_cmd_key(ctl_cmd_key), .ctl_cmd_value(ctl_cmd_value), .ctl_cmd_ttl(ctl_cmd_ttl),
        .ctl_cmd_ready(ctl_cmd_ready), .ctl_resp_valid(ctl_resp_valid),
        .ctl_resp_success(ctl_resp_success), .ctl_resp_value(ctl_resp_value),
        .ctl_resp_ttl(ctl_resp_ttl), .ctl_resp_ready(ctl_resp_ready),
        .busy(busy), .grant_idx(grant_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [63:0] val;
        logic [31:0] ttl;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    int          ptr_m  = 0;
    logic [63:0] key_tbl[N];
    logic [7:0]  op_tbl[N];
    logic [N-1:0] obs_rsp_valid;
    logic [63:0]  obs_rsp_value;
    logic [31:0]  obs_rsp_ttl;
    logic [IW-1:0] obs_grant;

    function automatic int model_winner(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] op, input logic [63:0] k,
                           input logic [63:0] v, input logic [31:0] t);
        req_opcode[i*CW +: CW] = op;
        req_key[i*KW +: KW]    = k;
        req_value[i*VW +: VW]  = v;
        req_ttl[i*TW +: TW]    = t;
    endtask

    task automatic load_all();
        for (int i = 0; i < N; i++) begin
            op_tbl[i]  = 8'h10 + 8'(i);
            key_tbl[i] = 64'hC0FF_EE00_0000_1000 + 64'(i * 17);
            set_req(i, op_tbl[i], key_tbl[i], 64'h7700 + 64'(i), 32'd200 + 32'(i));
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req_valid = '0; rsp_ready = '0; ctl_cmd_ready = 1'b0; ctl_resp_valid = 1'b0;
        ctl_resp_success = 1'b0; ctl_resp_value = '0; ctl_resp_ttl = '0;
        tick();
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        sb_q.delete();
    endtask

    // Drives one command from ISSUE through to the response handshake; the controller
    // answers with a value derived from the key it saw, so routing and data are both visible.
    task automatic finish_txn();
        logic [63:0] k;
        ctl_cmd_ready = 1'b1;
        @(negedge clk);
        k = ctl_cmd_key;
        tick();
        ctl_cmd_ready    = 1'b0;
        ctl_resp_valid   = 1'b1;
        ctl_resp_success = 1'b1;
        ctl_resp_value   = k ^ VMASK;
        ctl_resp_ttl     = k[31:0] ^ TMASK;
        tick();
        ctl_resp_valid = 1'b0;
        rsp_ready      = 4'hF;
        @(negedge clk);
        obs_rsp_valid = rsp_valid;
        obs_rsp_value = rsp_value;
        obs_rsp_ttl   = rsp_ttl;
        obs_grant     = grant_idx;
        tick();
        rsp_ready = '0;
    endtask

    task automatic test_reset();
        reset_dut();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++;
            $display("FAIL rst_busy got %0h want 0", busy); end
        checks++; if (ctl_cmd_valid !== 1'b0) begin errors++;
            $display("FAIL rst_cmd_valid got %0h want 0", ctl_cmd_valid); end
        checks++; if (ctl_resp_ready !== 1'b0) begin errors++;
            $display("FAIL rst_resp_ready got %0h want 0", ctl_resp_ready); end
        checks++; if (rsp_valid !== 4'b0) begin errors++;
            $display("FAIL rst_rsp_valid got %0h want 0", rsp_valid); end
        checks++; if (grant_idx !== 2'd0) begin errors++;
            $display("FAIL rst_grant got %0h want 0", grant_idx); end
        checks++; if ({rsp_success, rsp_value, rsp_ttl} !== '0) begin errors++;
            $display("FAIL rst_rsp_fields got %0h/%0h want 0", rsp_value, rsp_ttl); end
        tick();
    endtask

    task automatic test_single();
        set_req(2, 8'h01, 64'hA5, 64'h1234, 32'd100);
        req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++;
            $display("FAIL single_ready got %0h want 4", req_ready); end
        tick();
        req_valid = '0;
        @(negedge clk);
        checks++; if (ctl_cmd_valid !== 1'b1 || ctl_cmd_opcode !== 8'h01) begin errors++;
            $display("FAIL single_cmd got v=%0h op=%0h want 1/01", ctl_cmd_valid, ctl_cmd_opcode); end
        checks++; if (ctl_cmd_key !== 64'hA5 || ctl_cmd_value !== 64'h1234 ||
                      ctl_cmd_ttl !== 32'd100) begin errors++;
            $display("FAIL single_fields got %0h/%0h/%0d want a5/1234/100",
                     ctl_cmd_key, ctl_cmd_value, ctl_cmd_ttl); end
        checks++; if (grant_idx !== 2'd2 || busy !== 1'b1) begin errors++;
            $display("FAIL single_grant got %0d busy=%0h want 2/1", grant_idx, busy); end
        ctl_cmd_ready = 1'b1;
        tick();
        ctl_cmd_ready = 1'b0;
        @(negedge clk);
        checks++; if (ctl_cmd_valid !== 1'b0 || ctl_resp_ready !== 1'b1) begin errors++;
            $display("FAIL single_wait got cv=%0h rr=%0h want 0/1", ctl_cmd_valid, ctl_resp_ready); end
        ctl_resp_valid = 1'b1; ctl_resp_success = 1'b1;
        ctl_resp_value = 64'h1234; ctl_resp_ttl = 32'd55;
        tick();
        ctl_resp_valid = 1'b0; ctl_resp_success = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0100 || ctl_resp_ready !== 1'b0) begin errors++;
            $display("FAIL single_rsp got %0h rr=%0h want 4/0", rsp_valid, ctl_resp_ready); end
        checks++; if (rsp_success !== 1'b1 || rsp_value !== 64'h1234 || rsp_ttl !== 32'd55)
        begin errors++;
            $display("FAIL single_rsp_fields got %0h/%0h/%0d want 1/1234/55",
                     rsp_success, rsp_value, rsp_ttl); end
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL single_done got %0h busy=%0h want 0/0", rsp_valid, busy); end
        ptr_m = 3;
        tick();
    endtask

    task automatic test_round_robin(input logic [N-1:0] v, input int n, input string tag);
        int w;
        req_valid = v;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            w = model_winner(req_valid, ptr_m);
            sb_q.push_back('{w, key_tbl[w] ^ VMASK, key_tbl[w][31:0] ^ TMASK});
            checks++; if (req_ready !== N'(1 << w)) begin errors++;
                $display("FAIL %s_ready[%0d] got %0h want %0h", tag, t, req_ready, N'(1 << w)); end
            tick();
            finish_txn();
            e = sb_q.pop_front();
            checks++; if (obs_rsp_valid !== N'(1 << e.idx) || obs_grant !== IW'(e.idx)) begin
                errors++;
                $display("FAIL %s_route[%0d] got %0h g=%0d want %0h g=%0d", tag, t,
                         obs_rsp_valid, obs_grant, N'(1 << e.idx), e.idx); end
            checks++; if (obs_rsp_value !== e.val || obs_rsp_ttl !== e.ttl) begin errors++;
                $display("FAIL %s_data[%0d] got %0h/%0h want %0h/%0h", tag, t,
                         obs_rsp_value, obs_rsp_ttl, e.val, e.ttl); end
            ptr_m = (e.idx + 1) % N;
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++;
            $display("FAIL bp_ready got %0h want 2", req_ready); end
        tick();
        req_valid = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (ctl_cmd_valid !== 1'b1 || ctl_cmd_key !== key_tbl[1] ||
                          ctl_cmd_opcode !== op_tbl[1] || req_ready !== 4'b0) begin errors++;
                $display("FAIL bp_issue[%0d] got v=%0h k=%0h op=%0h rdy=%0h want 1/%0h/%0h/0", c,
                         ctl_cmd_valid, ctl_cmd_key, ctl_cmd_opcode, req_ready,
                         key_tbl[1], op_tbl[1]); end
            tick();
        end
        ctl_cmd_ready = 1'b1;
        tick();
        ctl_cmd_ready = 1'b0;
        ctl_resp_valid = 1'b1; ctl_resp_value = 64'hBEEF; ctl_resp_ttl = 32'd9;
        tick();
        ctl_resp_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 4'b0010 || rsp_value !== 64'hBEEF ||
                          req_ready !== 4'b0) begin errors++;
                $display("FAIL bp_deliver[%0d] got v=%0h val=%0h rdy=%0h want 2/beef/0", c,
                         rsp_valid, rsp_value, req_ready); end
            tick();
        end
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = '0;
        @(negedge clk);
        checks++; if (req_ready !== N'(1 << model_winner(4'hF, 2)) || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_next got %0h busy=%0h want 4/0", req_ready, busy); end
        req_valid = '0;
        ptr_m = 2;
        tick();
    endtask

    task automatic test_spurious();
        req_valid = 4'b0100;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++;
            $display("FAIL sp_ready got %0h want 4", req_ready); end
        tick();
        req_valid = '0;
        ctl_resp_valid = 1'b1; ctl_resp_value = 64'hDEAD;
        @(negedge clk);
        checks++; if (ctl_resp_ready !== 1'b0) begin errors++;
            $display("FAIL sp_issue_rr got %0h want 0", ctl_resp_ready); end
        tick();
        ctl_resp_valid = 1'b0;
        @(negedge clk);
        checks++; if (ctl_cmd_valid !== 1'b1 || rsp_valid !== 4'b0) begin errors++;
            $display("FAIL sp_issue_hold got cv=%0h rv=%0h want 1/0", ctl_cmd_valid, rsp_valid); end
        ctl_cmd_ready = 1'b1;
        tick();
        ctl_cmd_ready = 1'b0;
        ctl_resp_valid = 1'b1; ctl_resp_value = 64'h600D;
        tick();
        ctl_resp_value = 64'hBAD0;
        rsp_ready = 4'b1011;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 4'b0100 || rsp_value !== 64'h600D || busy !== 1'b1) begin
                errors++;
                $display("FAIL sp_deliver[%0d] got v=%0h val=%0h busy=%0h want 4/600d/1", c,
                         rsp_valid, rsp_value, busy); end
            tick();
        end
        ctl_resp_valid = 1'b0;
        rsp_ready = 4'b0100;
        tick();
        rsp_ready = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL sp_done got %0h busy=%0h want 0/0", rsp_valid, busy); end
        ptr_m = 3;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 4'b1000;
        @(negedge clk);
        checks++; if (req_ready !== 4'b1000) begin errors++;
            $display("FAIL rw_ready got %0h want 8", req_ready); end
        tick();
        req_valid = '0;
        ctl_cmd_ready = 1'b1;
        tick();
        ctl_cmd_ready = 1'b0;
        @(negedge clk);
        checks++; if (ctl_resp_ready !== 1'b1) begin errors++;
            $display("FAIL rw_wait got %0h want 1", ctl_resp_ready); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || ctl_cmd_valid !== 1'b0 || ctl_resp_ready !== 1'b0 ||
                      rsp_valid !== 4'b0 || grant_idx !== 2'd0) begin errors++;
            $display("FAIL rw_after got b=%0h cv=%0h rr=%0h rv=%0h g=%0d want all 0",
                     busy, ctl_cmd_valid, ctl_resp_ready, rsp_valid, grant_idx); end
        ptr_m = 0;
        tick();
        test_round_robin(4'hF, 1, "post_rst");
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_opcode = '0; req_key = '0; req_value = '0; req_ttl = '0;
        rsp_ready = '0; ctl_cmd_ready = 1'b0; ctl_resp_valid = 1'b0;
        ctl_resp_success = 1'b0; ctl_resp_value = '0; ctl_resp_ttl = '0;
        test_reset();
        test_single();
        load_all();
        reset_dut();
        test_round_robin(4'hF, 8, "fair");
        test_round_robin(4'b0100, 1, "wrap_pre");
        test_round_robin(4'b1001, 2, "wrap");
        test_backpressure();
        test_spurious();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_rr_arbiter.md
Name: cmd_rr_arbiter

Overview:
- Shares the single command/response port of the command FSM controller between N_REQ independent requesters, e.g. host bridge, TTL sweeper, debug port.
- Round-robin arbitration, one outstanding command system-wide.
- Routes the controller's response back to the requester that issued the command.
- Sits between the requester fabric and the controller's cmd_*/resp_* interface.

Parameters:
- N_REQ, 4, number of requesters (≥2)
- IDX_WIDTH, 2, width of requester index; must be ≥ clog2(N_REQ)
- KEY_WIDTH, 64, key width
- VALUE_WIDTH, 64, value width
- TTL_WIDTH, 32, TTL width
- CMD_WIDTH, 8, opcode width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  N_REQ  per-requester command valid
- req_opcode  in  N_REQ*CMD_WIDTH  flattened opcodes; requester i at slice [i*CMD_WIDTH +: CMD_WIDTH]
- req_key  in  N_REQ*KEY_WIDTH  flattened keys
- req_value  in  N_REQ*VALUE_WIDTH  flattened values
- req_ttl  in  N_REQ*TTL_WIDTH  flattened TTLs
- req_ready  out  N_REQ  one-hot accept
- rsp_valid  out  N_REQ  one-hot response valid
- rsp_success  out  1  response hit/success; broadcast
- rsp_value  out  VALUE_WIDTH  response value; broadcast
- rsp_ttl  out  TTL_WIDTH  response TTL; broadcast
- rsp_ready  in  N_REQ  per-requester response ready
- ctl_cmd_valid  out  1  command valid to controller
- ctl_cmd_opcode  out  CMD_WIDTH  opcode to controller
- ctl_cmd_key  out  KEY_WIDTH  key to controller
- ctl_cmd_value  out  VALUE_WIDTH  value to controller
- ctl_cmd_ttl  out  TTL_WIDTH  TTL to controller
- ctl_cmd_ready  in  1  controller ready
- ctl_resp_valid  in  1  controller response valid
- ctl_resp_success  in  1  controller response success
- ctl_resp_value  in  VALUE_WIDTH  controller response value
- ctl_resp_ttl  in  TTL_WIDTH  controller response TTL
- ctl_resp_ready  out  1  ready to controller
- busy  out  1  transaction in flight (state != IDLE)
- grant_idx  out  IDX_WIDTH  index of current/last granted requester

Behaviour:
- Single clock clk. Reset rst_n is synchronous, active-low.
- Reset values: state=IDLE; rr_ptr=0; grant_idx=0; all holding registers 0; ctl_cmd_valid=0; ctl_resp_ready=0; rsp_valid=0; rsp_success/value/ttl=0; busy=0.
- req_ready is combinational: in IDLE, one-hot of the winning requester; 0 in every other state.
- Winner: first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod N_REQ.
- State IDLE:
  - if any req_valid: accept the winner this cycle (req_valid & req_ready).
  - Latch its opcode/key/value/ttl; grant_idx <= winner; go to ISSUE.
- State ISSUE:
  - ctl_cmd_valid=1 with the latched fields, held stable.
  - On ctl_cmd_valid & ctl_cmd_ready: go to WAIT. ctl_cmd_valid is 0 from the next cycle.
- State WAIT:
  - ctl_resp_ready=1.
  - On ctl_resp_valid: latch success/value/ttl; ctl_resp_ready drops next cycle; go to DELIVER.
- State DELIVER:
  - rsp_valid[grant_idx]=1, all other bits 0; rsp_* fields held stable.
  - On rsp_ready[grant_idx]: rsp_valid=0, rr_ptr <= (grant_idx+1) mod N_REQ, go to IDLE.
- Latency:
  - accept at cycle T → ctl_cmd_valid at T+1.
  - ctl_resp_valid at cycle R → rsp_valid at R+1.
  - rsp handshake at D → next accept possible at D+1. No back-to-back accept without an IDLE cycle.
- Only one command is outstanding. req_valid on other requesters is held off (req_ready=0) until IDLE.
- ctl_resp_valid in IDLE/ISSUE/DELIVER is ignored (ctl_resp_ready=0).
- rsp_ready from non-granted requesters is ignored.
- rr_ptr wraps N_REQ-1 → 0. Arbitration is fair: a continuously requesting requester waits at most N_REQ-1 grants.
- A requester deasserting req_valid before acceptance is legal and never granted.
- busy = (state != IDLE), registered.
- Reset asserted mid-transaction:
  - abandons the transaction and returns to reset values next cycle.
  - No response is delivered. The controller is reset alongside.

Test Plan:
- Single request: req_valid=4'b0100, opcode 8'h01, key 64'hA5, value 64'h1234, ttl 32'd100 → req_ready=4'b0100 same cycle; ctl_cmd_* match next cycle; ctl_resp success=1, value 64'h1234 → rsp_valid=4'b0100 next cycle; grant_idx=2.
- Round-robin fairness: all four req_valid held high, 8 transactions → grant order 0,1,2,3,0,1,2,3.
- Wrap: rr_ptr=3, req_valid=4'b1001 → grant 3, then grant 0.
- Backpressure: ctl_cmd_ready=0 for 5 cycles in ISSUE → ctl_cmd_valid and fields stable, req_ready=0. rsp_ready[granted]=0 for 3 cycles → rsp_valid and rsp_value stable, no new accept.
- Spurious inputs: ctl_resp_valid pulsed during ISSUE, rsp_ready on a non-granted requester during DELIVER → no state change.
- Reset mid-WAIT: rst_n low one cycle → next cycle busy=0, all valids 0, rr_ptr=0. Subsequent req_valid=4'b1111 → grant 0.
